// File: rtl/vote_session_ctrl.sv
// Voting-booth session controller: arms one ballot, forwards a single vote to the logger, then locks out.
// Optional armed-session idle timeout is enabled by defining VOTE_TIMEOUT_EN.
module vote_session_ctrl #(
  parameter int LOCKOUT_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             arm,
  input  logic [3:0]       vote_req,
  input  logic             log_ack,
  output logic [3:0]       vote_grant,
  output logic             ready,
  output logic             busy,
  output logic             reject,
  output logic             timeout,
  output logic [CNT_W-1:0] session_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_GRANT, S_LOCKOUT} state_t;

  localparam int              LOCK_W    = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  generate
    if (LOCKOUT_CYCLES < 1 || TIMEOUT_CYCLES < 2 || CNT_W < 1) begin : g_bad_param
      $error("vote_session_ctrl: parameter out of range");
    end
  endgenerate

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_grant, w_grant_nxt;
  logic              r_reject, w_reject_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_cnt_inc;
  logic [LOCK_W-1:0] r_lock_cnt, w_lock_nxt;
  logic              w_one_hot, w_multi;

`ifdef VOTE_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_nxt;
  logic             r_timeout, w_timeout_nxt;
`endif

  // A press counts as a vote only when exactly one candidate button is down.
  assign w_one_hot = (vote_req != 4'd0) && ((vote_req & (vote_req - 4'd1)) == 4'd0);
  assign w_multi   = (vote_req != 4'd0) && !w_one_hot;

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_reject_nxt = 1'b0;
    w_cnt_inc    = 1'b0;
    w_lock_nxt   = r_lock_cnt;
`ifdef VOTE_TIMEOUT_EN
    w_tmo_nxt     = r_tmo_cnt;
    w_timeout_nxt = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (arm && !mode) begin
          w_state_nxt = S_ARMED;
`ifdef VOTE_TIMEOUT_EN
          w_tmo_nxt   = '0;
`endif
        end
      end
      S_ARMED: begin
        // Mode switch wins over any simultaneous button press.
        if (mode) begin
          w_state_nxt = S_IDLE;
        end else if (w_one_hot) begin
          w_state_nxt = S_GRANT;
          w_grant_nxt = vote_req;
        end else if (w_multi) begin
          w_reject_nxt = 1'b1;
`ifdef VOTE_TIMEOUT_EN
          w_tmo_nxt    = '0;
`endif
        end else begin
`ifdef VOTE_TIMEOUT_EN
          if (r_tmo_cnt == TMO_LAST) begin
            w_state_nxt   = S_IDLE;
            w_timeout_nxt = 1'b1;
          end else begin
            w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
          end
`endif
        end
      end
      S_GRANT: begin
        if (log_ack) begin
          w_state_nxt = S_LOCKOUT;
          w_grant_nxt = 4'd0;
          w_cnt_inc   = 1'b1;
          w_lock_nxt  = LOCK_LAST;
        end
      end
      S_LOCKOUT: begin
        if (r_lock_cnt == '0) w_state_nxt = S_IDLE;
        else                  w_lock_nxt  = r_lock_cnt - LOCK_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_grant    <= 4'd0;
      r_reject   <= 1'b0;
      r_cnt      <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_reject   <= w_reject_nxt;
      r_lock_cnt <= w_lock_nxt;
      if (w_cnt_inc && r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef VOTE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_tmo_cnt <= w_tmo_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  assign vote_grant  = r_grant;
  assign ready       = (r_state == S_ARMED);
  assign busy        = (r_state == S_GRANT) || (r_state == S_LOCKOUT);
  assign reject      = r_reject;
  assign session_cnt = r_cnt;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Self-checking bench for vote_session_ctrl: directed scenarios plus randomized traffic against a ballot-level model.
// Timeout scenarios are exercised when VOTE_TIMEOUT_EN is defined.
module tb_vote_session_ctrl;

  localparam int LOCK    = 16;
  localparam int TMO     = 10;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, mode, arm, log_ack;
  logic [3:0]       vote_req;
  logic [3:0]       vote_grant;
  logic             ready, busy, reject, timeout;
  logic [CNT_W-1:0] session_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Ballot-level model: an open ballot, a pending vote, lockout cycles left, pulse flags.
  bit         m_armed;
  logic [3:0] m_pending;
  int         m_lock_left;
  int         m_waited;
  int         m_count;
  bit         m_rej, m_tmo;

  vote_session_ctrl #(.LOCKOUT_CYCLES(LOCK), .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .arm        (arm),
    .vote_req   (vote_req),
    .log_ack    (log_ack),
    .vote_grant (vote_grant),
    .ready      (ready),
    .busy       (busy),
    .reject     (reject),
    .timeout    (timeout),
    .session_cnt(session_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ones(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  task automatic model_update();
    if (!reset) begin
      m_armed = 0; m_pending = 4'd0; m_lock_left = 0; m_waited = 0;
      m_count = 0; m_rej = 0; m_tmo = 0;
    end else begin
      m_rej = 0;
      m_tmo = 0;
      if (m_pending != 4'd0) begin
        if (log_ack) begin
          m_pending   = 4'd0;
          m_count     = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
          m_lock_left = LOCK;
        end
      end else if (m_lock_left > 0) begin
        m_lock_left--;
      end else if (m_armed) begin
        if (mode) begin
          m_armed = 0;
        end else if (ones(vote_req) == 1) begin
          m_armed   = 0;
          m_pending = vote_req;
        end else if (ones(vote_req) >= 2) begin
          m_rej    = 1;
          m_waited = 0;
        end else begin
`ifdef VOTE_TIMEOUT_EN
          m_waited++;
          if (m_waited == TMO) begin
            m_armed = 0;
            m_tmo   = 1;
          end
`endif
        end
      end else if (arm && !mode) begin
        m_armed  = 1;
        m_waited = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("grant",   vote_grant,  m_pending);
    check("ready",   ready,       m_armed);
    check("busy",    busy,        (m_pending != 4'd0) || (m_lock_left > 0));
    check("reject",  reject,      m_rej);
    check("timeout", timeout,     m_tmo);
    check("cnt",     session_cnt, m_count);
  endtask

  // Apply one cycle of inputs (starting from a falling edge), advance the model, compare at the next falling edge.
  task automatic step(input logic rst_n_i, input logic arm_i, input logic mode_i,
                      input logic [3:0] vote_i, input logic ack_i);
    reset    = rst_n_i;
    arm      = arm_i;
    mode     = mode_i;
    vote_req = vote_i;
    log_ack  = ack_i;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 4'd0, 0);
  endtask

  task automatic ballot(input logic [3:0] v);
    step(1, 1, 0, 4'd0, 0);
    step(1, 0, 0, v, 0);
    step(1, 0, 0, 4'd0, 1);
    idle(LOCK + 1);
  endtask

  initial begin
    int busy_cycles;
    reset = 0; arm = 0; mode = 0; vote_req = 4'd0; log_ack = 0;
    @(negedge clk);

    // Reset state.
    step(0, 1, 0, 4'b0001, 1);
    step(0, 0, 0, 4'd0, 0);
    check("rst_ready", ready, 1'b0);
    check("rst_cnt", session_cnt, 0);

    // Single vote, held until ack, then a 16-cycle lockout.
    step(1, 1, 0, 4'd0, 0);
    check("arm_ready", ready, 1'b1);
    step(1, 0, 0, 4'b0100, 0);
    check("v0100_grant", vote_grant, 4'b0100);
    idle(3);
    check("v0100_held", vote_grant, 4'b0100);
    step(1, 0, 1, 4'd0, 0);
    check("grant_vs_mode", vote_grant, 4'b0100);
    step(1, 0, 0, 4'd0, 1);
    check("ack_grant", vote_grant, 4'd0);
    check("ack_cnt", session_cnt, 1);
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cycles++;
      step(1, 0, 0, 4'd0, 0);
    end
    check("lock_len", busy_cycles, LOCK);

    // Multi-press reject, then a valid press.
    step(1, 1, 0, 4'd0, 0);
    step(1, 0, 0, 4'b0011, 0);
    check("rej_pulse", reject, 1'b1);
    check("rej_ready", ready, 1'b1);
    check("rej_nogrant", vote_grant, 4'd0);
    step(1, 0, 0, 4'b0001, 0);
    check("rej_after", reject, 1'b0);
    check("v0001_grant", vote_grant, 4'b0001);
    step(1, 0, 0, 4'd0, 1);
    idle(LOCK + 1);

    // Presses in IDLE, arm and presses during LOCKOUT, press with mode priority.
    step(1, 0, 0, 4'b0010, 1);
    check("idle_press", vote_grant, 4'd0);
    step(1, 1, 0, 4'd0, 0);
    step(1, 0, 0, 4'b1000, 0);
    step(1, 0, 0, 4'd0, 1);
    for (int i = 0; i < LOCK; i++) step(1, 1, 0, 4'b0100, 0);
    check("lock_nogrant", vote_grant, 4'd0);
    step(1, 1, 0, 4'd0, 0);
    step(1, 0, 1, 4'b0010, 0);
    check("mode_prio", vote_grant, 4'd0);
    check("mode_idle", ready, 1'b0);

    // Saturating counter with CNT_W=2.
    step(0, 0, 0, 4'd0, 0);
    ballot(4'b0001); check("sat1", session_cnt, 1);
    ballot(4'b0010); check("sat2", session_cnt, 2);
    ballot(4'b0100); check("sat3", session_cnt, 3);
    ballot(4'b1000); check("sat4", session_cnt, 3);

    // Reset in the middle of GRANT.
    step(1, 1, 0, 4'd0, 0);
    step(1, 0, 0, 4'b0010, 0);
    step(0, 1, 0, 4'b0001, 1);
    check("midrst_grant", vote_grant, 4'd0);
    check("midrst_cnt", session_cnt, 0);
    check("midrst_busy", busy, 1'b0);

`ifdef VOTE_TIMEOUT_EN
    step(1, 1, 0, 4'd0, 0);
    idle(TMO - 1);
    check("tmo_early", timeout, 1'b0);
    check("tmo_still_armed", ready, 1'b1);
    idle(1);
    check("tmo_pulse", timeout, 1'b1);
    check("tmo_ready", ready, 1'b0);
    idle(1);
    check("tmo_one_cycle", timeout, 1'b0);
`else
    step(1, 1, 0, 4'd0, 0);
    idle(TMO + 5);
    check("no_tmo_armed", ready, 1'b1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic       r_n, a, m, k;
      logic [3:0] v;
      r_n = ($urandom_range(0, 199) != 0);
      a   = ($urandom_range(0, 9) < 3);
      m   = ($urandom_range(0, 19) == 0);
      k   = ($urandom_range(0, 9) < 3);
      v   = ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : 4'd0;
      step(r_n, a, m, v, k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
